// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_adc_ctrl
// Brief    : Parametrised SAR ADC sequencer (track/hold, DAC trial code,
//            comparator bit trials). Optional averaging with SAR_AVG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int AVG_LOG2      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont_mode,
  input  logic             comp_in,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES + 1) ? SAMPLE_CYCLES : SETTLE_CYCLES + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] c_sample_last = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES);
  localparam logic [BIT_W-1:0] c_msb         = BIT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   partial_q, partial_d;
  logic               sample_en_q, sample_en_d;
  logic [WIDTH-1:0]   dac_code_q, dac_code_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic [WIDTH-1:0]   w_code;

`ifdef SAR_AVG_EN
  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int AVG_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [AVG_W-1:0] c_avg_last = AVG_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [AVG_W-1:0]   avg_cnt_q, avg_cnt_d;
  logic [ACC_W-1:0]   w_sum;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    partial_d = partial_q;
    result_d  = result_q;
    // Code with the current trial bit resolved by the comparator.
    w_code    = partial_q | (comp_in ? (c_one << bit_q) : '0);
`ifdef SAR_AVG_EN
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    w_sum     = acc_q + ACC_W'(w_code);
`endif

    case (state_q)
      S_IDLE: begin
        if (start || cont_mode) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
`ifdef SAR_AVG_EN
          acc_d     = '0;
          avg_cnt_d = '0;
`endif
        end
      end
      S_SAMPLE: begin
        if (cnt_q == c_sample_last) begin
          state_d   = S_CONVERT;
          cnt_d     = '0;
          bit_d     = c_msb;
          partial_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CONVERT: begin
        if (cnt_q != c_settle_last) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d     = '0;
          partial_d = w_code;
          if (bit_q != '0) begin
            bit_d = bit_q - 1'b1;
          end else begin
`ifdef SAR_AVG_EN
            if (avg_cnt_q == c_avg_last) begin
              state_d  = S_DONE;
              result_d = WIDTH'(w_sum >> AVG_LOG2);
            end else begin
              // Next conversion of the group starts with no idle gap.
              state_d   = S_SAMPLE;
              acc_d     = w_sum;
              avg_cnt_d = avg_cnt_q + 1'b1;
            end
`else
            state_d  = S_DONE;
            result_d = w_code;
`endif
          end
        end
      end
      S_DONE: begin
        if (cont_mode) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
`ifdef SAR_AVG_EN
          acc_d     = '0;
          avg_cnt_d = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    sample_en_d    = (state_d == S_SAMPLE);
    busy_d         = (state_d == S_SAMPLE) || (state_d == S_CONVERT);
    dac_code_d     = (state_d == S_CONVERT) ? (partial_d | (c_one << bit_d)) : '0;
    result_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      bit_q          <= '0;
      partial_q      <= '0;
      sample_en_q    <= 1'b0;
      dac_code_q     <= '0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
`ifdef SAR_AVG_EN
      acc_q          <= '0;
      avg_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      partial_q      <= partial_d;
      sample_en_q    <= sample_en_d;
      dac_code_q     <= dac_code_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
`ifdef SAR_AVG_EN
      acc_q          <= acc_d;
      avg_cnt_q      <= avg_cnt_d;
`endif
    end
  end

  assign sample_en    = sample_en_q;
  assign dac_code     = dac_code_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_adc_ctrl
// Brief    : Directed self-checking bench for sar_adc_ctrl (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont_mode = 1'b0;
  logic       comp_in;
  logic       sample_en;
  logic [7:0] dac_code;
  logic       busy;
  logic [7:0] result;
  logic       result_valid;
  logic [7:0] vin = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int rv_count = 0;
  int conv_cnt = 0;

  logic [7:0] trace  [0:127];
  logic       busy_tr[0:127];

  sar_adc_ctrl #(
    .WIDTH         (8),
    .SAMPLE_CYCLES (2),
    .SETTLE_CYCLES (1),
    .AVG_LOG2      (2)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cont_mode    (cont_mode),
    .comp_in      (comp_in),
    .sample_en    (sample_en),
    .dac_code     (dac_code),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  always @(posedge sample_en) conv_cnt++;

`ifdef SAR_AVG_EN
  // Input alternates 0x10 / 0x13 on each successive conversion.
  assign comp_in = ((conv_cnt[0] ? 8'h13 : 8'h10) >= dac_code);
`else
  assign comp_in = (vin >= dac_code);
`endif

  always @(negedge clk) if (result_valid === 1'b1) rv_count++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle k is the k-th cycle after the edge that samples start.
  task automatic run_conv(input logic [7:0] v, output int lat);
    vin = v;
    lat = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      trace[k]   = dac_code;
      busy_tr[k] = busy;
      if (result_valid === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int rv0;
    int np;
    int pulses[0:2];
    logic [7:0] res[0:2];
    logic [7:0] exp_trials[0:7];
    exp_trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    repeat (3) @(negedge clk);
    check_eq("rst_sample_en", sample_en, 0);
    check_eq("rst_dac_code", dac_code, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_result_valid", result_valid, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef SAR_AVG_EN
    for (int g = 0; g < 2; g++) begin
      int gap;
      gap = 0;
      lat = 0;
      rv0 = rv_count;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int k = 1; k <= 200; k++) begin
        if (result_valid === 1'b1) begin
          lat = k;
          break;
        end
        if (busy !== 1'b1) gap = 1;
        @(negedge clk);
      end
      check_eq($sformatf("avg%0d_latency", g), lat, 73);
      check_eq($sformatf("avg%0d_result", g), result, 8'h11);
      check_eq($sformatf("avg%0d_busy_gap", g), gap, 0);
      repeat (20) @(negedge clk);
      check_eq($sformatf("avg%0d_rv_pulses", g), rv_count - rv0, 1);
    end
    check_eq("avg_idle_busy", busy, 0);
`else
    // Vin = 0xA5: latency, result and full trial sequence.
    run_conv(8'hA5, lat);
    check_eq("a5_latency", lat, 19);
    check_eq("a5_result", result, 8'hA5);
    check_eq("a5_sample_dac", trace[1], 0);
    check_eq("a5_busy_first", busy_tr[1], 1);
    check_eq("a5_busy_last_cmp", busy_tr[18], 1);
    check_eq("a5_busy_done", busy_tr[19], 0);
    for (int j = 0; j < 8; j++) begin
      check_eq($sformatf("a5_trial%0d_a", j), trace[3 + 2 * j], exp_trials[j]);
      check_eq($sformatf("a5_trial%0d_b", j), trace[4 + 2 * j], exp_trials[j]);
    end
    @(negedge clk);
    check_eq("a5_rv_one_cycle", result_valid, 0);
    check_eq("a5_result_held", result, 8'hA5);
    check_eq("a5_done_dac", dac_code, 0);

    // Extremes.
    run_conv(8'h00, lat);
    check_eq("zero_latency", lat, 19);
    check_eq("zero_result", result, 8'h00);
    run_conv(8'hFF, lat);
    check_eq("ff_latency", lat, 19);
    check_eq("ff_result", result, 8'hFF);
    check_eq("ff_last_trial", trace[18], 8'hFF);
    repeat (3) @(negedge clk);
    check_eq("idle_busy", busy, 0);

    // start re-pulsed during CONVERT is ignored.
    vin = 8'h3C;
    lat = 0;
    rv0 = rv_count;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      start = (k == 6);
      if (result_valid === 1'b1 && lat == 0) lat = k;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("ign_latency", lat, 19);
    check_eq("ign_result", result, 8'h3C);
    check_eq("ign_rv_pulses", rv_count - rv0, 1);
    run_conv(8'h66, lat);
    check_eq("after_done_latency", lat, 19);
    check_eq("after_done_result", result, 8'h66);

    // Asynchronous reset at cycle 10 of a conversion.
    vin = 8'h77;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_sample_en", sample_en, 0);
    check_eq("abort_dac_code", dac_code, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_result", result, 0);
    check_eq("abort_result_valid", result_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    run_conv(8'h5A, lat);
    check_eq("post_abort_latency", lat, 19);
    check_eq("post_abort_result", result, 8'h5A);

    // Continuous mode with stepping input.
    vin = 8'h10;
    np = 0;
    pulses = '{0, 0, 0};
    res = '{8'h00, 8'h00, 8'h00};
    @(negedge clk) cont_mode = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        pulses[np] = k;
        res[np]    = result;
        np++;
        if (np == 1) vin = 8'h40;
        if (np == 2) vin = 8'h7F;
        if (np == 3) begin
          cont_mode = 1'b0;
          break;
        end
      end
    end
    cont_mode = 1'b0;
    check_eq("cont_pulses", np, 3);
    check_eq("cont_first_latency", pulses[0], 19);
    check_eq("cont_gap1", pulses[1] - pulses[0], 19);
    check_eq("cont_gap2", pulses[2] - pulses[1], 19);
    check_eq("cont_res0", res[0], 8'h10);
    check_eq("cont_res1", res[1], 8'h40);
    check_eq("cont_res2", res[2], 8'h7F);
    @(negedge clk);
    rv0 = rv_count;
    repeat (30) @(negedge clk);
    check_eq("cont_stop_rv", rv_count - rv0, 0);
    check_eq("cont_stop_busy", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Parametrised successive-approximation controller, successor to the fixed 8-bit SAR core in the tt_um_VanceWiberg_top tile. Drives the off-core track/hold switch and N-bit DAC code, and sequences bit trials from an external comparator. Adds configurable width, sample and settle timing, continuous mode and optional oversampling.

Parameters:
WIDTH, 8, conversion resolution in bits (2..12)
SAMPLE_CYCLES, 2, cycles sample_en is held high per conversion (>=1)
SETTLE_CYCLES, 1, DAC settle cycles before each compare (>=0)
AVG_LOG2, 2, log2 of conversions averaged per result; used only with SAR_AVG_EN (0..4)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request; sampled in IDLE only
cont_mode  input  1  1 = restart automatically after each result
comp_in  input  1  comparator: 1 = Vin >= Vdac; synchronous to clk, sampled only on compare cycles
sample_en  output  1  1 = track, 0 = hold
dac_code  output  WIDTH  trial code to DAC
busy  output  1  high from SAMPLE entry through last compare cycle
result  output  WIDTH  last completed conversion, held until the next one completes
result_valid  output  1  one-cycle pulse when result updates

Behaviour:
- Reset, asynchronous: state IDLE, sample_en=0, dac_code=0, busy=0, result=0, result_valid=0; all counters and the accumulator cleared.
- IDLE: dac_code=0. start=1 or cont_mode=1 at a clock edge -> SAMPLE on the next cycle.
- SAMPLE: sample_en=1, dac_code=0, busy=1 for exactly SAMPLE_CYCLES cycles -> CONVERT with bit index WIDTH-1.
- CONVERT, per bit i from MSB to LSB:
  - dac_code = partial | (1<<i), held SETTLE_CYCLES+1 cycles.
  - comp_in sampled on the last of those cycles: 1 keeps bit i, 0 clears it.
  - sample_en=0 throughout.
- After the LSB compare -> DONE, a single cycle:
  - result <= partial; result_valid=1; busy=0; dac_code=0.
  - Then IDLE. If cont_mode=1, the next cycle enters SAMPLE directly.
- Latency, start edge to result_valid cycle: 1 + SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1). Defaults give 19 cycles.
- start outside IDLE is ignored and not queued.
- Deasserting cont_mode mid-conversion completes the current conversion, then the block stays in IDLE.
- Reset mid-conversion aborts the conversion: partial code is discarded and result returns to 0.
- Width rule: all codes are WIDTH bits unsigned. No overflow is possible; the partial code never exceeds 2^WIDTH-1.

Optional Feature:
Macro SAR_AVG_EN.
- Defined: runs 2^AVG_LOG2 back-to-back conversions per result. Each conversion gets full SAMPLE and CONVERT phases, with no IDLE gap between them.
- Codes are summed in a (WIDTH+AVG_LOG2)-bit accumulator, cleared at the first SAMPLE.
- result = accumulator >> AVG_LOG2, truncated. result_valid pulses once per average; busy stays high across the whole group.
- Undefined: AVG_LOG2 is ignored and each conversion produces a result, as described above.

Test Plan:
- Comparator model Vin=0xA5 (comp_in = Vin>=dac_code), defaults, start pulse -> result=0xA5, result_valid exactly 19 cycles after the start edge; dac_code trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5.
- Vin=0x00, then Vin=0xFF -> result 0x00, then 0xFF; busy low only in IDLE/DONE.
- start re-pulsed during CONVERT -> ignored; exactly one result_valid; next start accepted only after DONE.
- rst_n low at cycle 10 of a conversion -> immediately sample_en=0, dac_code=0, busy=0, result=0; a fresh start gives the correct code.
- cont_mode=1, Vin stepping 0x10 -> 0x40 -> 0x7F -> results 0x10, 0x40, 0x7F with result_valid pulses exactly 19 cycles apart.
- SAR_AVG_EN, AVG_LOG2=2, Vin alternating 0x10/0x13 per conversion -> single result 0x11 after 4*18+1=73 cycles.
